// File: rtl/fpmult_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier among NREQ requesters,
// with a LATENCY-deep in-order pipeline. Define FPMULT_ZERO_EN to flush zero-exponent operands.
module fpmult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_m,
  input  logic [NREQ-1:0]   resp_ready,
  output logic              busy
);

  localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PD = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [LATENCY-1:0] v_q;
  logic [TW-1:0]      tag_q [LATENCY];
  logic [31:0]        a_q, b_q;
  logic [31:0]        prod_q [PD];
  logic [TW-1:0]      rr_q;

  logic               last_v;
  logic [TW-1:0]      last_tag;
  logic               adv_c;
  logic               gnt_c;
  logic [TW-1:0]      gidx_c;
  logic [30:0]        mag_c;
  logic [31:0]        p1_c;
  logic [31:0]        a_arr [NREQ];
  logic [31:0]        b_arr [NREQ];

  // Unsigned datapath: hidden-one mantissa product, truncated, exponent wraps mod 256.
  function automatic logic [30:0] fpm(input logic [30:0] a, input logic [30:0] b);
    logic [24:0] top;
    logic [7:0]  e;
    top = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
    e   = a[30:23] + b[30:23] - 8'd127 + 8'(top[24]);
    fpm = {e, top[24] ? top[23:1] : top[22:0]};
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  assign last_v   = v_q[LATENCY-1];
  assign last_tag = tag_q[LATENCY-1];
  assign adv_c    = !(last_v && !resp_ready[last_tag]);

  // Rotating-priority search starting at rr_q; no grant while stalled or in reset.
  always_comb begin
    logic [TW-1:0] idx;
    gnt_c  = 1'b0;
    gidx_c = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = TW'((32'(rr_q) + k) % NREQ);
      if (!gnt_c && req_valid[idx]) begin
        gnt_c  = 1'b1;
        gidx_c = idx;
      end
    end
    if (!(adv_c && reset_n)) begin
      gnt_c = 1'b0;
    end
  end

  assign req_ready = gnt_c ? (NREQ'(1) << gidx_c) : '0;

  always_comb begin
    mag_c = fpm(a_q[30:0], b_q[30:0]);
`ifdef FPMULT_ZERO_EN
    if (a_q[30:23] == 8'd0 || b_q[30:23] == 8'd0) begin
      mag_c = '0;
    end
`else
    mag_c = mag_c;
`endif
    p1_c = {a_q[31] ^ b_q[31], mag_c};
  end

  // Global shift on advance, global hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q  <= '0;
      rr_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) tag_q[k] <= '0;
      for (int unsigned j = 0; j < PD; j++) prod_q[j] <= '0;
    end else if (adv_c) begin
      v_q[0]    <= gnt_c;
      tag_q[0]  <= gidx_c;
      a_q       <= a_arr[gidx_c];
      b_q       <= b_arr[gidx_c];
      prod_q[0] <= p1_c;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        v_q[k]   <= v_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      for (int unsigned j = 1; j < PD; j++) prod_q[j] <= prod_q[j-1];
      if (gnt_c) begin
        rr_q <= (32'(gidx_c) == NREQ - 1) ? '0 : gidx_c + 1'b1;
      end
    end
  end

  assign resp_valid = last_v ? (NREQ'(1) << last_tag) : '0;
  assign busy       = |v_q;

  if (LATENCY == 1) begin : g_lat1
    assign resp_m = last_v ? p1_c : '0;
  end else begin : g_latn
    assign resp_m = prod_q[PD-1];
  end

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Randomized bench for fpmult_arbiter against a queue/age-counter reference model.
module tb_fpmult_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned LATENCY = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  resp_m;
  logic         busy;

  always #5 clk = ~clk;

  fpmult_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_m(resp_m),
    .resp_ready(resp_ready), .busy(busy)
  );

  int nvec = 0;
  int nerr = 0;

  // In-flight items in acceptance order; cnt = advancing edges since acceptance.
  int          q_tag[$];
  logic [31:0] q_prod[$];
  int          q_cnt[$];
  int          rr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, p;
    int e;
    logic [31:0] r;
    ma = 64'h80_0000 | 64'(a[22:0]);
    mb = 64'h80_0000 | 64'(b[22:0]);
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      p = p >> 1;
      e = e + 1;
    end
    r = {a[31] ^ b[31], 8'(e), 23'(p >> 23)};
`ifdef FPMULT_ZERO_EN
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) r = {a[31] ^ b[31], 31'b0};
`endif
    return r;
  endfunction

  task automatic model_clear();
    q_tag.delete();
    q_prod.delete();
    q_cnt.delete();
    rr = 0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = $urandom;
      req_b[32*i +: 32] = $urandom;
    end
  endtask

  // One cycle: compare outputs in the low phase, then update the model at the edge.
  task automatic step();
    bit          out_v, adv;
    int          g, idx;
    logic [3:0]  er, ev;
    logic [31:0] ga, gb;
    #1;
    out_v = (q_cnt.size() > 0) && (q_cnt[0] == LATENCY);
    ev    = out_v ? 4'(1 << q_tag[0]) : 4'b0;
    adv   = out_v ? resp_ready[q_tag[0]] : 1'b1;
    g     = -1;
    if (adv && reset_n) begin
      for (int k = 0; k < 4; k++) begin
        idx = (rr + k) % 4;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    check("req_ready", 32'(req_ready), 32'(er));
    check("resp_valid", 32'(resp_valid), 32'(ev));
    if (out_v) check("resp_m", resp_m, q_prod[0]);
    check("busy", 32'(busy), 32'(q_cnt.size() > 0));
    ga = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
    gb = (g >= 0) ? req_b[32*g +: 32] : 32'h0;
    @(posedge clk);
    if (reset_n && adv) begin
      if (out_v) begin
        void'(q_tag.pop_front());
        void'(q_prod.pop_front());
        void'(q_cnt.pop_front());
      end
      foreach (q_cnt[i]) q_cnt[i]++;
      if (g >= 0) begin
        q_tag.push_back(g);
        q_prod.push_back(ref_mul(ga, gb));
        q_cnt.push_back(1);
        rr = (g + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    repeat (LATENCY + 2) step();
  endtask

  task automatic single(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    rand_ops();
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid  = 4'(1 << idx);
    resp_ready = '1;
    step();
    req_valid = '0;
    repeat (LATENCY - 1) step();
    check("single_valid", 32'(resp_valid), 32'(1 << idx));
    check("single_m", resp_m, exp);
    drain();
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    rand_ops();
    @(negedge clk);
    req_valid = 4'hF;
    step();
    check("rst_m", resp_m, 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    reset_n   = 1'b1;

    // Basic 2.0 * 3.0 through requester 0
    rand_ops();
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    req_valid   = 4'b0001;
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (LATENCY - 1) step();
    check("t1_valid", 32'(resp_valid), 32'h1);
    check("t1_m", resp_m, 32'h40C0_0000);
    drain();

    // All requesters valid: strict rotation from 0
    do_reset();
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    for (int j = 0; j < 8; j++) begin
      rand_ops();
      #1 check("t2_grant", 32'(req_ready), 32'(1 << (j % 4)));
      step();
    end
    drain();

    single(2, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    single(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
`ifdef FPMULT_ZERO_EN
    single(0, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000);
`else
    single(0, 32'h0000_0000, 32'h40A0_0000, 32'h0120_0000);
`endif

    // Output stall for 3 cycles, then resume
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    repeat (4) begin
      rand_ops();
      step();
    end
    resp_ready = 4'h0;
    repeat (3) begin
      #1 check("t4_stall_ready", 32'(req_ready), 32'h0);
      step();
    end
    resp_ready = 4'hF;
    repeat (4) begin
      rand_ops();
      step();
    end
    drain();

    // Reset with two products in flight
    do_reset();
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    step();
    step();
    reset_n = 1'b0;
    model_clear();
    #1;
    check("t6_valid", 32'(resp_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_m", resp_m, 32'h0);
    check("t6_ready", 32'(req_ready), 32'h0);
    step();
    reset_n   = 1'b1;
    req_valid = '0;
    repeat (4) step();
    req_valid = 4'hF;
    #1 check("t6_first", 32'(req_ready), 32'h1);
    step();
    drain();

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
